// File: rtl/lru_victim_ctrl.sv
// lru_victim_ctrl
// ---------------
// Replacement controller for a 2-way set-associative cache. It holds one LRU
// bit per set, where the bit names the way to evict next in that set. For each
// lookup it reports either the hitting way or the victim way for a fill. It
// updates the LRU bit when a hit is reported and when a fill completes.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   req_valid         lookup request, accepted only in IDLE
//   req_ready         high while the controller is IDLE
//   req_index         set index of the lookup
//   hit0, hit1        raw tag-compare result per way
//   valid0, valid1    line-valid bit per way
//   resp_valid        one-cycle response pulse, one cycle after acceptance
//   resp_hit          response is a hit
//   resp_way          hit way, or victim way on a miss
//   resp_evict        miss victim holds a valid line that must be replaced
//   fill_done         miss FSM finished filling the victim way
//   err               one-cycle pulse when both ways report a qualified hit
//   busy              controller is not IDLE
module lru_victim_ctrl #(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               hit0,
    input  logic               hit1,
    input  logic               valid0,
    input  logic               valid1,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic               resp_way,
    output logic               resp_evict,
    input  logic               fill_done,
    output logic               err,
    output logic               busy
);

    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  idx_q;
    logic                hit0_q, hit1_q;
    logic                valid0_q, valid1_q;
    logic                victim_q, victim_d;
    logic [SETS-1:0]     lru_q, lru_d;

    logic                accept;
    logic                effHit0, effHit1;
    logic                lookupHit;
    logic                hitWay;
    logic                missVictim;

    // Lookup results are derived from the values latched at acceptance, so the
    // tag/valid inputs are free to change while the response is being produced.
    always_comb begin
        accept     = (state_q == IDLE) && req_valid;
        effHit0    = hit0_q & valid0_q;
        effHit1    = hit1_q & valid1_q;
        lookupHit  = effHit0 | effHit1;
        // A double hit resolves to way 0.
        hitWay     = ~effHit0;
        // An empty way is always preferred over evicting a valid line.
        if (!valid0_q) begin
            missVictim = 1'b0;
        end else if (!valid1_q) begin
            missVictim = 1'b1;
        end else begin
            missVictim = lru_q[idx_q];
        end
    end

    // State register, request latches, victim latch and LRU array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hit0_q   <= 1'b0;
            hit1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            lru_q    <= lru_d;
            if (accept) begin
                idx_q    <= req_index;
                hit0_q   <= hit0;
                hit1_q   <= hit1;
                valid0_q <= valid0;
                valid1_q <= valid1;
            end
        end
    end

    // Next-state logic. Every LRU write stores the complement of the way just
    // used, and always lands before the next request can be accepted.
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        lru_d    = lru_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookupHit) begin
                    lru_d[idx_q] = ~hitWay;
                    state_d      = IDLE;
                end else begin
                    victim_d = missVictim;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (fill_done) begin
                    lru_d[idx_q] = ~victim_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. Response fields are forced to 0 outside the LOOKUP cycle.
    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        resp_way   = 1'b0;
        resp_evict = 1'b0;
        err        = 1'b0;
        if (state_q == LOOKUP) begin
            resp_valid = 1'b1;
            resp_hit   = lookupHit;
            resp_way   = lookupHit ? hitWay : missVictim;
            resp_evict = ~lookupHit & (missVictim ? valid1_q : valid0_q);
            err        = effHit0 & effHit1;
        end
    end

endmodule
